// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge on a single shared clock.
// One transfer in flight; HREADYOUT stretches the AHB data phase until APB completes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for an address phase, HREADYOUT=1
// W_DATA | write data phase, capture HWDATA into PWDATA
// SETUP  | APB setup phase, PSEL=1 PENABLE=0
// ACCESS | APB access phase, wait for PREADY or watchdog expiry
// ERR1   | first ERROR cycle, HREADYOUT=0 HRESP=1
// ERR2   | second ERROR cycle, HREADYOUT=1 HRESP=1
module ahb_apb_bridge #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_DATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
    } state_t;

    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t                  state, state_nxt;
    logic [WDW-1:0]          wdog_cnt, wdog_nxt;
    logic                    hreadyout_nxt, hresp_nxt, psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_nxt, hrdata_nxt;
    logic                    accept, illegal, wdog_hit;
    logic                    unused_htrans;

    assign unused_htrans = HTRANS[0];
    assign accept   = HSEL & HREADY & HTRANS[1];
    assign illegal  = (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00);
    // Fires on the ACCESS cycle that would make the stall count reach the limit
    assign wdog_hit = (TIMEOUT_CYCLES != 0) && ((32'(wdog_cnt) + 32'd1) >= TIMEOUT_CYCLES);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            wdog_cnt  <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            state     <= state_nxt;
            wdog_cnt  <= wdog_nxt;
            HREADYOUT <= hreadyout_nxt;
            HRESP     <= hresp_nxt;
            HRDATA    <= hrdata_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (illegal)     state_nxt = S_ERR1;
                    else if (HWRITE) state_nxt = S_W_DATA;
                    else             state_nxt = S_SETUP;
                end
            end
            S_W_DATA: state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (PREADY)        state_nxt = S_IDLE;
                else if (wdog_hit) state_nxt = S_ERR1;
            end
            S_ERR1:   state_nxt = S_ERR2;
            S_ERR2:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered
    always_comb begin
        hreadyout_nxt = (state_nxt == S_IDLE) || (state_nxt == S_ERR2);
        hresp_nxt     = (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
        psel_nxt      = (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
        penable_nxt   = (state_nxt == S_ACCESS);
        paddr_nxt     = PADDR;
        pwrite_nxt    = PWRITE;
        pwdata_nxt    = PWDATA;
        hrdata_nxt    = HRDATA;
        wdog_nxt      = '0;
        if (state == S_IDLE && accept && !illegal) begin
            paddr_nxt  = HADDR;
            pwrite_nxt = HWRITE;
        end
        if (state == S_W_DATA)
            pwdata_nxt = HWDATA;
        if (state == S_ACCESS && PREADY && !PWRITE)
            hrdata_nxt = PRDATA;
        if (state == S_ACCESS && !PREADY && !wdog_hit)
            wdog_nxt = wdog_cnt + WDW'(1);
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: schedule-based transfer model plus directed checks.
module tb_ahb_apb_bridge;

    localparam int TMO = 4;
    localparam int N   = 400;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HADDR = '0;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic        HREADYOUT, HRESP, PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] HRDATA, PADDR, PWDATA, PRDATA;

    ahb_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // APB slave: PREADY held low for the first stall_n ACCESS cycles of each transfer
    logic [31:0] slave_mem [16];
    int acc_cnt = 0;
    int stall_n = 0;
    assign PREADY = (acc_cnt >= stall_n);
    assign PRDATA = slave_mem[PADDR[5:2]];
    always @(posedge HCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) slave_mem[PADDR[5:2]] <= PWDATA;
    end

    // Model: each accepted transfer writes its expected output schedule into per-cycle tables
    logic        e_rdy [N];
    logic        e_resp[N];
    logic        e_psel[N];
    logic        e_pen [N];
    logic        e_pwr [N];
    logic [31:0] e_rdata[N];
    logic [31:0] e_addr [N];
    logic [31:0] e_wdata[N];
    logic [31:0] m_mem [16];
    int          pw_data_cyc = -1, pw_commit_cyc = -1, pw_setup = 0, pw_last = 0;
    logic [31:0] pw_addr = '0, pw_wdata = '0;
    int          m_c;

    task automatic set_idle(input int k, input logic [31:0] rd);
        e_rdy[k] = 1'b1; e_resp[k] = 1'b0; e_psel[k] = 1'b0; e_pen[k] = 1'b0;
        e_pwr[k] = 1'b0; e_rdata[k] = rd; e_addr[k] = '0; e_wdata[k] = '0;
    endtask

    task automatic schedule(input int c);
        int base, nacc, done;
        bit tmo;
        if (HSIZE != 3'b010 || HADDR[1:0] != 2'b00) begin
            e_rdy[c+1] = 1'b0; e_resp[c+1] = 1'b1;
            e_rdy[c+2] = 1'b1; e_resp[c+2] = 1'b1;
        end else begin
            base = c + 1 + (HWRITE ? 1 : 0);
            if (HWRITE) e_rdy[c+1] = 1'b0;
            tmo  = (TMO > 0) && (stall_n >= TMO);
            nacc = tmo ? TMO : stall_n + 1;
            for (int k = base; k <= base + nacc; k++) begin
                e_rdy[k] = 1'b0; e_psel[k] = 1'b1; e_pen[k] = (k != base);
                e_addr[k] = HADDR; e_pwr[k] = HWRITE;
            end
            done = base + nacc + 1;
            if (tmo) begin
                e_rdy[done] = 1'b0;   e_resp[done] = 1'b1;
                e_rdy[done+1] = 1'b1; e_resp[done+1] = 1'b1;
            end else if (!HWRITE) begin
                for (int k = done; k < N; k++) e_rdata[k] = m_mem[HADDR[5:2]];
            end
            if (HWRITE) begin
                pw_data_cyc   = c + 1;
                pw_setup      = base;
                pw_last       = base + nacc;
                pw_addr       = HADDR;
                pw_commit_cyc = tmo ? -1 : done - 1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 32'h1000_0000 + i;
            m_mem[i]     = 32'h1000_0000 + i;
        end
        slave_mem[3] = 32'hDEAD_BEEF;
        m_mem[3]     = 32'hDEAD_BEEF;
        for (int k = 0; k < N; k++) set_idle(k, '0);
    end

    always @(posedge HCLK) begin
        m_c = cyc;
        if (m_c + 16 < N) begin
            if (!HRESETn) begin
                for (int k = m_c + 1; k < N; k++) set_idle(k, '0);
                pw_data_cyc   = -1;
                pw_commit_cyc = -1;
            end else begin
                if (m_c == pw_data_cyc) begin
                    pw_wdata = HWDATA;
                    for (int k = pw_setup; k <= pw_last; k++) e_wdata[k] = HWDATA;
                end
                if (m_c == pw_commit_cyc) m_mem[pw_addr[5:2]] = pw_wdata;
                if (HSEL && HREADY && HTRANS[1] && e_rdy[m_c] && !e_resp[m_c]) schedule(m_c);
            end
        end
    end

    always @(negedge HCLK) begin
        if (cyc >= 1 && cyc < N) begin
            chk("hreadyout", HREADYOUT, e_rdy[cyc]);
            chk("hresp", HRESP, e_resp[cyc]);
            chk("psel", PSEL, e_psel[cyc]);
            chk("penable", PENABLE, e_pen[cyc]);
            chk("hrdata", HRDATA, e_rdata[cyc]);
            if (e_psel[cyc]) begin
                chk("paddr", PADDR, e_addr[cyc]);
                chk("pwrite", PWRITE, e_pwr[cyc]);
                if (e_pwr[cyc]) chk("pwdata", PWDATA, e_wdata[cyc]);
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr(input logic w, input logic [31:0] a, input logic [2:0] sz);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a; HSIZE = sz; HREADY = 1'b1;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HSIZE = 3'b010;
    endtask

    logic [31:0] hold_addr, hold_data;

    initial begin
        repeat (3) tick();
        chk("rst_hreadyout", HREADYOUT, 1'b1);
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b1;
        tick();

        // read 0x0C, zero-wait
        addr(1'b0, 32'h0C, 3'b010);
        chk("rd_c1_psel", PSEL, 1'b1);
        chk("rd_c1_penable", PENABLE, 1'b0);
        tick();
        chk("rd_c2_penable", PENABLE, 1'b1);
        tick();
        chk("rd_c3_hreadyout", HREADYOUT, 1'b1);
        chk("rd_c3_hrdata", HRDATA, 32'hDEAD_BEEF);
        chk("rd_c3_hresp", HRESP, 1'b0);
        tick();

        // write 0x10 then back-to-back read
        addr(1'b1, 32'h10, 3'b010);
        HWDATA = 32'hA5A5_5A5A;
        tick();
        chk("wr_setup_pwdata", PWDATA, 32'hA5A5_5A5A);
        tick();
        chk("wr_access_pwdata", PWDATA, 32'hA5A5_5A5A);
        chk("wr_access_hreadyout", HREADYOUT, 1'b0);
        tick();
        chk("wr_c4_hreadyout", HREADYOUT, 1'b1);
        addr(1'b0, 32'h10, 3'b010);
        HWDATA = '0;
        tick();
        tick();
        chk("b2b_rd_hrdata", HRDATA, 32'hA5A5_5A5A);
        tick();

        // write with three PREADY=0 cycles
        stall_n = 3;
        addr(1'b1, 32'h14, 3'b010);
        HWDATA = 32'h1234_5678;
        tick();
        tick();
        hold_addr = PADDR;
        hold_data = PWDATA;
        chk("stall_paddr", PADDR, 32'h14);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_paddr_hold", PADDR, hold_addr);
            chk("stall_pwdata_hold", PWDATA, hold_data);
            chk("stall_access", PSEL & PENABLE, 1'b1);
            chk("stall_hreadyout", HREADYOUT, 1'b0);
        end
        tick();
        chk("stall_done", HREADYOUT, 1'b1);
        stall_n = 0;
        HWDATA = '0;
        tick();
        chk("stall_mem", slave_mem[5], 32'h1234_5678);

        // illegal size, then a read offered during ERR2
        addr(1'b0, 32'h18, 3'b000);
        chk("bad_size_psel", PSEL, 1'b0);
        chk("bad_size_err1", {HRESP, HREADYOUT}, 2'b10);
        tick();
        chk("bad_size_err2", {HRESP, HREADYOUT}, 2'b11);
        addr(1'b0, 32'h0C, 3'b010);
        chk("err2_ignored", PSEL, 1'b0);
        chk("bad_size_idle", {HRESP, HREADYOUT}, 2'b01);
        tick();

        // misaligned address
        addr(1'b1, 32'h02, 3'b010);
        chk("bad_addr_err1", {HRESP, HREADYOUT, PSEL}, 3'b100);
        tick();
        chk("bad_addr_err2", {HRESP, HREADYOUT}, 2'b11);
        tick();
        chk("bad_addr_idle", {HRESP, HREADYOUT, PSEL}, 3'b010);

        // watchdog timeout
        stall_n = 20;
        addr(1'b0, 32'h0C, 3'b010);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_access", {PSEL, PENABLE}, 2'b11);
            tick();
        end
        chk("tmo_err1", {PSEL, HRESP, HREADYOUT}, 3'b010);
        tick();
        chk("tmo_err2", {HRESP, HREADYOUT}, 2'b11);
        tick();
        chk("tmo_idle", {HRESP, HREADYOUT}, 2'b01);
        stall_n = 0;

        // HTRANS=IDLE with HSEL, and a NONSEQ with HREADY low
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h0C;
        repeat (3) begin
            tick();
            chk("htrans_idle", {PSEL, HRESP, HREADYOUT}, 3'b001);
        end
        HTRANS = 2'b10; HREADY = 1'b0;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
        chk("hready_low_psel", PSEL, 1'b0);
        tick();

        // reset during ACCESS
        stall_n = 10;
        addr(1'b0, 32'h10, 3'b010);
        tick();
        HRESETn = 1'b0;
        tick();
        chk("mid_rst_apb", {PSEL, PENABLE}, 2'b00);
        chk("mid_rst_ahb", {HRESP, HREADYOUT}, 2'b01);
        chk("mid_rst_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b1;
        stall_n = 0;
        addr(1'b0, 32'h0C, 3'b010);
        tick();
        tick();
        chk("post_rst_rd", HRDATA, 32'hDEAD_BEEF);
        chk("post_rst_rdy", HREADYOUT, 1'b1);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
